// File: rtl/tmds_decoder_dvi.sv
// tmds_decoder_dvi
//   Receive-side TMDS decoder for one DVI colour channel. Raw 10-bit
//   deserializer words arrive with an unknown bit alignment. The block hunts
//   for the symbol boundary by looking for runs of control tokens at each of
//   the ten possible bit offsets. Once locked, it decodes every symbol into
//   8-bit colour data, a 2-bit control value and display enable.
//
// Ports
//   i_clk     symbol clock, one 10-bit word per cycle
//   i_rst_n   asynchronous active-low reset
//   i_tmds    raw deserializer word, bit 0 received first
//   o_data    decoded colour data (0 outside data periods or while unlocked)
//   o_ctrl    last decoded control value, held through data periods
//   o_de      high for a decoded data symbol while locked
//   o_locked  high while symbol alignment is locked
//   o_offset  bit offset currently used to frame symbols (0..9)
module tmds_decoder_dvi #(
  parameter int CTRL_RUN     = 8,
  parameter int SLIP_WAIT    = 1024,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // TMDS data decode: undo the optional inversion (bit 9), then undo the
  // XOR/XNOR transition chain selected by bit 8.
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_t             state;
  logic [9:0]         r_prev;
  logic [9:0]         r_sym;
  logic [RUN_W-1:0]   run_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [19:0]        win_p0;
  logic [4:0]         sel_p0;
  logic               is_tok_p1;
  logic [1:0]         tok_ctrl_p1;
  logic [7:0]         dec_p1;

  // ---- stage p0: framing window and symbol register ----
  // The newer word sits above the older one, so offset 0 is the previous
  // word unchanged and larger offsets pull in low bits of the current word.
  assign win_p0 = {i_tmds, r_prev};
  assign sel_p0 = {1'b0, o_offset};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
      r_sym  <= '0;
    end else begin
      r_prev <= i_tmds;
      r_sym  <= win_p0[sel_p0 +: 10];
    end
  end

  // ---- stage p1: token detection, alignment FSM, output registers ----
  always_comb begin
    is_tok_p1   = 1'b1;
    tok_ctrl_p1 = 2'b00;
    case (r_sym)
      10'b1101010100: tok_ctrl_p1 = 2'b00;
      10'b0010101011: tok_ctrl_p1 = 2'b01;
      10'b0101010100: tok_ctrl_p1 = 2'b10;
      10'b1010101011: tok_ctrl_p1 = 2'b11;
      default:        is_tok_p1   = 1'b0;
    endcase
  end

  assign dec_p1 = tmds_decode(r_sym);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= SEARCH;
      run_cnt  <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
      o_offset <= '0;
      o_locked <= 1'b0;
      o_de     <= 1'b0;
      o_data   <= '0;
      o_ctrl   <= '0;
    end else begin
      case (state)
        SEARCH: begin
          // Outputs stay at their cleared values while hunting.
          if (is_tok_p1) begin
            wait_cnt <= '0;
            run_cnt  <= run_cnt + 1'b1;
            if (run_cnt == RUN_LAST) begin
              state    <= LOCKED;
              o_locked <= 1'b1;
              to_cnt   <= '0;
            end
          end else begin
            run_cnt <= '0;
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= '0;
              o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (is_tok_p1) begin
            to_cnt <= '0;
            o_de   <= 1'b0;
            o_data <= '0;
            o_ctrl <= tok_ctrl_p1;
          end else if (to_cnt == TO_LAST) begin
            // Too long without a token: drop lock, keep the offset so the
            // hunt resumes from where alignment was last good.
            state    <= SEARCH;
            o_locked <= 1'b0;
            run_cnt  <= '0;
            wait_cnt <= '0;
            o_de     <= 1'b0;
            o_data   <= '0;
            o_ctrl   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            o_de   <= 1'b1;
            o_data <= dec_p1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
`timescale 1ns/1ps
module tb_tmds_decoder_dvi;

  localparam int CTRL_RUN     = 8;
  localparam int SLIP_WAIT    = 16;
  localparam int LOCK_TIMEOUT = 32;

  localparam logic [9:0] T0 = 10'h354;  // ctrl 00
  localparam logic [9:0] T1 = 10'h0AB;  // ctrl 01
  localparam logic [9:0] T2 = 10'h154;  // ctrl 10
  localparam logic [9:0] T3 = 10'h2AB;  // ctrl 11

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_offset;
  logic [15:0] outs;

  int n_vec = 0;
  int n_err = 0;
  int vid   = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned tgt;
    logic [15:0] exp;
    int          id;
  } exp_t;

  exp_t sbq[$];

  tmds_decoder_dvi #(
    .CTRL_RUN    (CTRL_RUN),
    .SLIP_WAIT   (SLIP_WAIT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_tmds  (i_tmds),
    .o_data  (o_data),
    .o_ctrl  (o_ctrl),
    .o_de    (o_de),
    .o_locked(o_locked),
    .o_offset(o_offset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign outs = {o_locked, o_offset, o_de, o_ctrl, o_data};

  function automatic logic [15:0] pk(input logic l, input logic [3:0] off,
                                     input logic de, input logic [1:0] c,
                                     input logic [7:0] d);
    return {l, off, de, c, d};
  endfunction

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {lock,off,de,ctrl,data}=%h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one word; if chk, queue the outputs expected two edges after the
  // edge that samples it.
  task automatic send(input logic [9:0] w, input logic chk, input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    i_tmds = w;
    if (chk) begin
      e.tgt = cyc + 3;
      e.exp = exp;
      e.id  = vid;
      vid++;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic hold_and_release();
    repeat (4) begin
      @(negedge clk);
      i_tmds = 10'($urandom);
    end
    @(negedge clk);
    i_tmds = '0;
    rst_n  = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].tgt < cyc) begin
      e = sbq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL vec%0d: check slot %0d missed at cycle %0d", e.id, e.tgt, cyc);
    end
    if (sbq.size() > 0 && sbq[0].tgt == cyc) begin
      e = sbq.pop_front();
      check($sformatf("vec%0d", e.id), outs, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] toks [4];
    logic [9:0] sym;
    logic [9:0] prev;
    logic [9:0] w;
    logic [15:0] e;
    int m;
    logic [3:0] off;
    toks[0] = T0; toks[1] = T1; toks[2] = T2; toks[3] = T3;

    // Reset with random input.
    rst_n  = 1'b0;
    i_tmds = 10'($urandom);
    repeat (4) begin
      @(negedge clk);
      i_tmds = 10'($urandom);
    end
    check("reset_hold", outs, 16'h0000);
    @(negedge clk);
    i_tmds = '0;
    rst_n  = 1'b1;

    // Aligned lock at offset 0.
    for (int j = 1; j <= 8; j++) send(T0, 1'b1, pk(j == 8, 4'd0, 1'b0, 2'd0, 8'h00));
    send(T0,     1'b1, pk(1, 0, 0, 2'd0, 8'h00));
    send(10'h100, 1'b1, pk(1, 0, 1, 2'd0, 8'h00));
    send(10'h200, 1'b1, pk(1, 0, 1, 2'd0, 8'hFF));
    send(10'h1AA, 1'b1, pk(1, 0, 1, 2'd0, 8'hFE));
    send(10'h30F, 1'b1, pk(1, 0, 1, 2'd0, 8'h10));
    send(10'h1FF, 1'b1, pk(1, 0, 1, 2'd0, 8'h01));

    // Control value held through a data period.
    send(T2, 1'b1, pk(1, 0, 0, 2'd2, 8'h00));
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 0) send(10'h100, 1'b1, pk(1, 0, 1, 2'd2, 8'h00));
      else            send(10'h200, 1'b1, pk(1, 0, 1, 2'd2, 8'hFF));
    end
    send(T1, 1'b1, pk(1, 0, 0, 2'd1, 8'h00));
    send(T3, 1'b1, pk(1, 0, 0, 2'd3, 8'h00));

    // Loss of lock after LOCK_TIMEOUT data symbols.
    for (int j = 1; j <= LOCK_TIMEOUT; j++) begin
      if (j < LOCK_TIMEOUT) send(10'h200, 1'b1, pk(1, 0, 1, 2'd3, 8'hFF));
      else                  send(10'h200, 1'b1, pk(0, 0, 0, 2'd0, 8'h00));
    end

    // Relock, then reset mid-lock.
    for (int j = 1; j <= 8; j++) send(T0, 1'b1, pk(j == 8, 4'd0, 1'b0, 2'd0, 8'h00));
    send(T3,      1'b1, pk(1, 0, 0, 2'd3, 8'h00));
    send(10'h200, 1'b1, pk(1, 0, 1, 2'd3, 8'hFF));
    drain();
    @(posedge clk);
    #1;
    check("pre_rst_locked", {15'b0, o_locked}, 16'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs, 16'h0000);
    hold_and_release();
    for (int j = 1; j <= 8; j++) send(T0, 1'b1, pk(j == 8, 4'd0, 1'b0, 2'd0, 8'h00));
    send(T1, 1'b1, pk(1, 0, 0, 2'd1, 8'h00));
    drain();

    // Misaligned stream: symbols delayed by 3 bits in the word stream.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    hold_and_release();
    prev = '0;
    for (int n = 2; n <= 66; n++) begin
      if (n <= 51)      sym = 10'h000;
      else if (n <= 63) sym = toks[(n - 52) % 4];
      else if (n == 65) sym = 10'h100;
      else              sym = 10'h000;
      w = {sym[6:0], prev[9:7]};
      m = n + 2;
      off = (m < 16) ? 4'd0 : (m < 32) ? 4'd1 : (m < 48) ? 4'd2 : 4'd3;
      if (n <= 58)      e = pk(0, off, 0, 2'd0, 8'h00);
      else if (n == 59) e = pk(1, off, 0, 2'd0, 8'h00);
      else if (n <= 63) e = pk(1, off, 0, 2'(n - 60), 8'h00);
      else if (n == 64) e = pk(1, off, 1, 2'd3, 8'hFE);
      else              e = pk(1, off, 1, 2'd3, 8'h00);
      send(w, n <= 65, e);
      prev = sym;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
